// File: rtl/lebug_pkg.sv
// Shared definitions for the vector serializer: default sizes, FSM state type
// and the lane-order packing helper used to flatten vectors into FIFO entries.
package lebug_pkg;

   localparam int unsigned DEFAULT_N          = 8;
   localparam int unsigned DEFAULT_DATA_WIDTH = 32;
   localparam int unsigned DEFAULT_OB_DEPTH   = 4;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Element 0 occupies the least significant lane of a packed entry.
   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/ram_dual_port.sv
// Simple dual-port storage: port A writes, port B reads with one cycle of latency.
// The read register only updates on a read, so it doubles as the holding register.
module ram_dual_port #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_a,
   input  logic [AW-1:0]    addr_a,
   input  logic [WIDTH-1:0] din_a,
   input  logic             re_b,
   input  logic [AW-1:0]    addr_b,
   output logic [WIDTH-1:0] dout_b
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we_a) begin
         mem[addr_a] <= din_a;
      end
      if (re_b) begin
         dout_b <= mem[addr_b];
      end
   end

endmodule

// File: rtl/vector_serializer.sv
// Buffers N-element vectors in a small FIFO and streams them out one element per
// accepted word, element 0 first, with last/eof markers on the final element.
module vector_serializer
   import lebug_pkg::*;
#(
   parameter int unsigned N          = DEFAULT_N,
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned OB_DEPTH   = DEFAULT_OB_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic                  eof_in,
   input  logic [DATA_WIDTH-1:0] vector_in [N-1:0],
   output logic                  ready_out,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  tx_last,
   output logic                  tx_eof,
   output logic                  overflow
);

   localparam int unsigned EW = N * DATA_WIDTH + 1;
   localparam int unsigned PW = $clog2(OB_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [IW-1:0] idx;
   state_t        state;

   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          last_beat;
   logic [EW-1:0] wr_entry;
   logic [EW-1:0] rd_entry;

   for (genvar i = 0; i < N; i++) begin : g_pack
      assign wr_entry[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = vector_in[i];
   end
   assign wr_entry[EW-1] = eof_in;

   assign full      = (count == CW'(OB_DEPTH));
   assign empty     = (count == '0);
   assign ready_out = !full;
   assign last_beat = (idx == IW'(N - 1));

   assign push = valid_in & !full;
   // Pop into the RAM read register when idle, or on the final accepted element.
   assign pop  = !empty & ((state == IDLE) | ((state == SEND) & tx_ready & last_beat));

   ram_dual_port #(
      .WIDTH (EW),
      .DEPTH (OB_DEPTH),
      .AW    (PW)
   ) u_ram (
      .clk    (clk),
      .we_a   (push),
      .addr_a (wr_ptr),
      .din_a  (wr_entry),
      .re_b   (pop),
      .addr_b (rd_ptr),
      .dout_b (rd_entry)
   );

   assign tx_valid = (state == SEND);
   assign tx_last  = tx_valid & last_beat;
   assign tx_eof   = tx_last & rd_entry[EW-1];
   assign tx_data  = tx_valid ? rd_entry[lane_lsb(32'(idx), DATA_WIDTH) +: DATA_WIDTH] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         idx      <= '0;
         state    <= IDLE;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (!push && pop) begin
            count <= count - 1'b1;
         end
         if (valid_in && full) begin
            overflow <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (!empty) begin
                  state <= SEND;
                  idx   <= '0;
               end
            end
            SEND: begin
               if (tx_ready) begin
                  if (!last_beat) begin
                     idx <= idx + 1'b1;
                  end else if (!empty) begin
                     idx <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vector_serializer.sv
// Directed bench for vector_serializer: latency, back-to-back, overflow, stalls
// and mid-frame reset, checked against hand-built expected word lists.
module tb_vector_serializer;

   logic        clk;
   logic        reset;
   logic        valid_in;
   logic        eof_in;
   logic [31:0] vector_in [7:0];
   logic        ready_out;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx_last;
   logic        tx_eof;
   logic        overflow;

   typedef struct packed {
      logic [31:0] d;
      logic        last;
      logic        eof;
   } word_t;

   word_t exp_q [$];
   int    n_checks = 0;
   int    n_errors = 0;

   vector_serializer dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (valid_in),
      .eof_in    (eof_in),
      .vector_in (vector_in),
      .ready_out (ready_out),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_last   (tx_last),
      .tx_eof    (tx_eof),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      valid_in = 1'b0;
      tx_ready = 1'b0;
      step();
      reset = 1'b0;
      exp_q.delete();
   endtask

   // Drives one vector for one cycle; valid_in is left high for back-to-back use.
   task automatic push_vec(input int base, input bit eof, input bit accept);
      for (int k = 0; k < 8; k++) begin
         vector_in[k] = 32'(base + k);
         if (accept) exp_q.push_back({32'(base + k), k == 7, eof && (k == 7)});
      end
      eof_in   = eof;
      valid_in = 1'b1;
      step();
   endtask

   task automatic drain(input int n_words, input int max_cycles, input bit stall,
                        input bit contig);
      int          got;
      bit          held;
      logic [31:0] held_d;
      word_t       w;
      got  = 0;
      held = 0;
      for (int c = 0; c < max_cycles && got < n_words; c++) begin
         if (held) begin
            chk("stall_valid", tx_valid, 1);
            chk("stall_data", tx_data, held_d);
         end
         if (contig) chk("contig_valid", tx_valid, 1);
         tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               chk("extra_word", tx_valid, 0);
            end else begin
               w = exp_q.pop_front();
               chk("data", tx_data, w.d);
               chk("last", tx_last, w.last);
               chk("eof", tx_eof, w.eof);
            end
            got++;
         end
         held   = tx_valid && !tx_ready;
         held_d = tx_data;
         step();
      end
      chk("word_count", got, n_words);
   endtask

   initial begin
      word_t w;
      int    seen;
      reset    = 1'b1;
      valid_in = 1'b0;
      eof_in   = 1'b0;
      tx_ready = 1'b0;
      for (int k = 0; k < 8; k++) vector_in[k] = '0;
      step();
      do_reset();
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_ready_out", ready_out, 1);
      chk("rst_overflow", overflow, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_last", tx_last, 0);
      chk("rst_tx_eof", tx_eof, 0);

      // Single vector 0..7 with eof: visible two cycles after the push.
      tx_ready = 1'b1;
      push_vec(0, 1, 1);
      valid_in = 1'b0;
      chk("lat_t1_idle", tx_valid, 0);
      step();
      drain(8, 8, 0, 1);
      chk("single_idle", tx_valid, 0);

      // Two vectors back-to-back: 16 contiguous words.
      do_reset();
      tx_ready = 1'b1;
      push_vec(100, 0, 1);
      push_vec(200, 1, 1);
      valid_in = 1'b0;
      drain(16, 16, 0, 1);
      chk("b2b_idle", tx_valid, 0);

      // Stalled output: one vector sits in the read register, four fill the FIFO.
      do_reset();
      for (int v = 0; v < 5; v++) begin
         push_vec(300 + 100 * v, v == 4, 1);
         chk("fill_ready", ready_out, v < 4);
      end
      chk("fill_no_ovf", overflow, 0);
      push_vec(800, 1, 0);
      valid_in = 1'b0;
      chk("ovf_set", overflow, 1);
      chk("ovf_ready", ready_out, 0);
      drain(40, 40, 0, 1);
      chk("ovf_idle", tx_valid, 0);
      chk("ovf_sticky", overflow, 1);

      // Full FIFO with push and pop in the same cycle: push is dropped.
      do_reset();
      for (int v = 0; v < 5; v++) push_vec(1000 + 100 * v, 0, 1);
      valid_in = 1'b0;
      chk("full_count", dut.count, 4);
      drain(7, 7, 0, 1);
      for (int k = 0; k < 8; k++) vector_in[k] = 32'(1500 + k);
      valid_in = 1'b1;
      tx_ready = 1'b1;
      w = exp_q.pop_front();
      chk("pp_data", tx_data, w.d);
      chk("pp_last", tx_last, 1);
      step();
      valid_in = 1'b0;
      chk("pp_count", dut.count, 3);
      chk("pp_overflow", overflow, 1);
      chk("pp_ready", ready_out, 1);
      drain(32, 32, 0, 1);
      chk("pp_idle", tx_valid, 0);

      // Random stalls across three vectors.
      do_reset();
      push_vec(2000, 0, 1);
      push_vec(2100, 0, 1);
      push_vec(2200, 1, 1);
      valid_in = 1'b0;
      drain(24, 400, 1, 0);
      step();
      chk("stall_idle", tx_valid, 0);

      // Reset at idx 3 with two vectors queued, push in the reset cycle ignored.
      do_reset();
      push_vec(3000, 0, 1);
      push_vec(3100, 0, 1);
      push_vec(3200, 1, 1);
      valid_in = 1'b0;
      drain(3, 3, 0, 1);
      for (int k = 0; k < 8; k++) vector_in[k] = 32'(3900 + k);
      tx_ready = 1'b0;
      reset    = 1'b1;
      valid_in = 1'b1;
      step();
      reset    = 1'b0;
      valid_in = 1'b0;
      exp_q.delete();
      chk("mid_rst_valid", tx_valid, 0);
      chk("mid_rst_ready", ready_out, 1);
      chk("mid_rst_count", dut.count, 0);
      chk("mid_rst_ovf", overflow, 0);
      seen     = 0;
      tx_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (tx_valid) seen++;
         step();
      end
      chk("mid_rst_quiet", seen, 0);
      push_vec(4000, 1, 1);
      valid_in = 1'b0;
      step();
      drain(8, 8, 0, 1);
      chk("post_rst_idle", tx_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
